reg_access_arbiter: RTL
=======================

Name: reg_access_arbiter

Overview:
- Shares the peripheral's generic register-array interface between two bus requesters, e.g. host bus adapter (port 0) and debug bridge (port 1).
- Round-robin arbitration, one access in flight, valid/ready request and response handshakes.
- Decodes the register index into one-hot write/read strobes, each exactly one cycle wide.
- Enforces per-register read/write permissions, so side-effect registers (FIFO pop/push) are never touched by illegal accesses.

Parameters:
- NREGS, 5, number of registers in the map
- AW, 3, register index width; must satisfy 2**AW >= NREGS
- RD_MASK, 5'b10111, bit i=1: register i readable
- WR_MASK, 5'b01011, bit i=1: register i writable

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- m_valid  in  2  request valid, per requester
- m_ready  out  2  request accepted, per requester
- m_write  in  2  1=write, 0=read, per requester
- m_addr  in  2*AW  register index, requester i at [i*AW +: AW]
- m_wdata  in  64  write data, requester i at [i*32 +: 32]
- s_valid  out  2  response valid, per requester
- s_ready  in  2  response accepted, per requester
- s_rdata  out  32  read data, shared; meaningful only with s_valid
- s_err  out  1  access error, shared; meaningful only with s_valid
- write_en  out  NREGS  one-hot register write strobe
- read_en  out  NREGS  one-hot register read strobe
- data_in  out  32  write data to register map
- data_out  in  NREGS*32  register read data, register i at [i*32 +: 32]

Behaviour:
- Reset: clk edge with reset=0. State=IDLE, last_grant=1 (requester 0 wins first). write_en, read_en, m_ready, s_valid, s_err all 0. s_rdata=0, data_in=0.
- Reset mid-operation: any in-flight access is abandoned on the next edge. No further strobe; no response is delivered.
- FSM states: IDLE, STROBE, RESP.
- IDLE:
  - If any m_valid: pick winner w. m_ready[w]=1 combinationally this cycle; the other m_ready stays 0.
  - Latch w, m_write, m_addr and m_wdata (into data_in). Go to STROBE.
  - Arbitration: if only one requester is valid, it wins. If both, winner = ~last_grant, and last_grant updates to w.
  - m_ready is never asserted outside IDLE.
- Legality: access is legal iff addr < NREGS AND (write ? WR_MASK[addr] : RD_MASK[addr]).
- STROBE (exactly 1 cycle):
  - Legal write: write_en[addr]=1.
  - Legal read: read_en[addr]=1, and s_rdata latches data_out[addr] at the end of this cycle. This is pre-pop data for side-effect registers.
  - Illegal access: no strobe, s_rdata<=0, s_err<=1.
  - Legal access: s_err<=0; legal write also sets s_rdata<=0.
  - Go to RESP.
- RESP:
  - s_valid[w]=1 from a register. s_rdata and s_err are held stable.
  - Stay in RESP until s_ready[w]=1, then go to IDLE on that edge.
  - s_ready of the non-winner is ignored.
- Latency: request accepted at cycle N, strobe at N+1, s_valid at N+2. Minimum 3 cycles per access, and a new accept cannot occur before N+3.
- Strobes: write_en | read_en has at most one bit set. Each strobe is asserted for exactly one cycle per access, and never while the FSM is in IDLE or RESP.
- data_in: held at the last accepted m_wdata between accesses.
- Requester holding m_valid while losing: keeps waiting with no timeout. Round-robin guarantees it is served by the next grant.
- Simultaneous m_valid rise on both ports with last_grant=1: port 0 wins. A pending port 1 wins the following arbitration.

Test Plan:
- After reset, port 0 writes addr 0, data 0x0000_1234 → m_ready[0] in the accept cycle. write_en=5'b00001 for exactly 1 cycle with data_in=0x1234. Then s_valid[0]=1, s_err=0.
- Port 1 reads addr 4 with data_out[4]=0xA5 → read_en=5'b10000 for 1 cycle; s_rdata=0x0000_00A5, s_err=0. Holding s_ready[1]=0 for 5 cycles keeps s_valid[1]=1 and s_rdata stable, with no second strobe.
- Both ports valid continuously with 4 accesses each → grants alternate 0,1,0,1…; no port is granted twice in a row.
- Illegal accesses: write addr 2, write addr 4, read addr 3, read addr 6 → write_en and read_en remain 0. Each response has s_err=1, s_rdata=0.
- reset=0 asserted during STROBE of a write to addr 3 → write_en is 0 from the next cycle. No s_valid follows; state is IDLE and the next request is accepted normally.
- Back-to-back port 0 reads of addr 2 with s_ready tied 1 → accepts at cycles N, N+3, N+6; read_en[2] pulses at N+1, N+4, N+7.

Source files
------------

// File: rtl/reg_access_arbiter_if.sv
// Requester-side bus of the register access arbiter: two request
// channels in, one shared response channel out, all valid/ready.
interface reg_access_arbiter_if #(
    parameter int AW = 3
);
    logic [1:0]      m_valid;
    logic [1:0]      m_ready;
    logic [1:0]      m_write;
    logic [2*AW-1:0] m_addr;
    logic [63:0]     m_wdata;
    logic [1:0]      s_valid;
    logic [1:0]      s_ready;
    logic [31:0]     s_rdata;
    logic            s_err;

    modport master (
        output m_valid, m_write, m_addr, m_wdata, s_ready,
        input  m_ready, s_valid, s_rdata, s_err
    );

    modport slave (
        input  m_valid, m_write, m_addr, m_wdata, s_ready,
        output m_ready, s_valid, s_rdata, s_err
    );
endinterface

// File: rtl/reg_access_arbiter.sv
// Round-robin sharing of a register-array port between two requesters,
// with one-cycle strobes and per-register read/write permission checks.
module reg_access_arbiter #(
    parameter int NREGS = 5,
    parameter int AW = 3,
    parameter logic [NREGS-1:0] RD_MASK = 5'b10111,
    parameter logic [NREGS-1:0] WR_MASK = 5'b01011
) (
    input  logic                  clk,
    input  logic                  reset,
    reg_access_arbiter_if.slave   bus,
    output logic [NREGS-1:0]      write_en,
    output logic [NREGS-1:0]      read_en,
    output logic [31:0]           data_in,
    input  logic [NREGS*32-1:0]   data_out
);
    typedef enum logic [1:0] {IDLE, STROBE, RESP} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic            win_q, win_d;
    logic            wr_q, wr_d;
    logic            err_q, err_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [NREGS-1:0] sel;
    logic             legal;
    logic             w;
    logic [31:0]      rd_mux;

    // Out-of-range indices match no select bit and so are illegal.
    always_comb begin
        sel = '0;
        rd_mux = '0;
        for (int i = 0; i < NREGS; i++) begin
            sel[i] = (addr_q == AW'(i));
            if (sel[i]) rd_mux = data_out[i*32 +: 32];
        end
        legal = |(sel & (wr_q ? WR_MASK : RD_MASK));
    end

    assign w = (bus.m_valid == 2'b11) ? ~last_q : bus.m_valid[1];

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        wr_d        = wr_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        bus.m_ready = 2'b00;
        write_en    = '0;
        read_en     = '0;
        unique case (state_q)
            IDLE: begin
                if (|bus.m_valid) begin
                    bus.m_ready[w] = 1'b1;
                    if (&bus.m_valid) last_d = w;
                    win_d   = w;
                    wr_d    = bus.m_write[w];
                    addr_d  = w ? bus.m_addr[2*AW-1:AW]
                                : bus.m_addr[AW-1:0];
                    wdata_d = w ? bus.m_wdata[63:32]
                                : bus.m_wdata[31:0];
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (legal && wr_q)  write_en = sel;
                if (legal && !wr_q) read_en  = sel;
                // Capture pre-pop data in the same cycle as the strobe.
                rdata_d = (legal && !wr_q) ? rd_mux : 32'd0;
                err_d   = ~legal;
                state_d = RESP;
            end
            RESP: begin
                if (bus.s_ready[win_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.s_valid = (state_q != RESP) ? 2'b00 :
                         (win_q ? 2'b10 : 2'b01);
    assign bus.s_rdata = rdata_q;
    assign bus.s_err   = err_q;
    assign data_in     = wdata_q;
endmodule
